// File: rtl/ts_queue_sched.sv
// ts_queue_sched: strict-priority transmit scheduler over four show-ahead
// packet FIFOs (Q0/Q1 time-triggered, Q2 bandwidth-reserved, Q3 best-effort).
//
// state | meaning
// IDLE  | waiting for any eligible queue; lowest index wins
// READ  | draining the selected FIFO word by word, stalling while it is empty
// DONE  | last word on the output, packet-done pulse, back to IDLE
module ts_queue_sched #(
    parameter int DW        = 134,
    parameter int MAX_WORDS = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    in_ts_schedule_valid,
    input  logic [3:0]    in_ts_fifo_empty,
    input  logic [DW-1:0] in_ts_q_data_0,
    input  logic [DW-1:0] in_ts_q_data_1,
    input  logic [DW-1:0] in_ts_q_data_2,
    input  logic [DW-1:0] in_ts_q_data_3,
    output logic [3:0]    out_ts_q_rden,
    output logic          out_ts_q2_rden,
    output logic [DW-1:0] out_ts_data,
    output logic          out_ts_data_wr,
    output logic [1:0]    out_ts_qsel,
    output logic          out_ts_pkt_valid,
    output logic          out_ts_err_trunc
);

    localparam int TAIL_BIT = DW - 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    qsel_q, qsel_d;
    logic [7:0]    word_cnt_q, word_cnt_d;
    logic          first_flag_q, first_flag_d;
    logic [DW-1:0] data_q, data_d;
    logic          data_wr_q, data_wr_d;
    logic          pkt_valid_q, pkt_valid_d;
    logic          err_trunc_q, err_trunc_d;

    logic [DW-1:0] head_word;
    logic [3:0]    rden;
    logic          rd_cycle;
    logic          at_limit;

    // Head word of the selected queue and the read strobe for this cycle.
    always_comb begin
        case (qsel_q)
            2'd0:    head_word = in_ts_q_data_0;
            2'd1:    head_word = in_ts_q_data_1;
            2'd2:    head_word = in_ts_q_data_2;
            default: head_word = in_ts_q_data_3;
        endcase
        rd_cycle = (state_q == READ) && !in_ts_fifo_empty[qsel_q];
        rden     = rd_cycle ? (4'b0001 << qsel_q) : 4'b0000;
        at_limit = (word_cnt_q == 8'(MAX_WORDS - 1));
    end

    // Next-state and next-output computation for the scheduler FSM.
    always_comb begin
        state_d      = state_q;
        qsel_d       = qsel_q;
        word_cnt_d   = word_cnt_q;
        first_flag_d = first_flag_q;
        data_d       = data_q;
        data_wr_d    = 1'b0;
        pkt_valid_d  = 1'b0;
        err_trunc_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|in_ts_schedule_valid) begin
                    if (in_ts_schedule_valid[0])      qsel_d = 2'd0;
                    else if (in_ts_schedule_valid[1]) qsel_d = 2'd1;
                    else if (in_ts_schedule_valid[2]) qsel_d = 2'd2;
                    else                              qsel_d = 2'd3;
                    first_flag_d = 1'b1;
                    word_cnt_d   = 8'd0;
                    state_d      = READ;
                end
            end
            READ: begin
                if (rd_cycle) begin
                    data_d       = head_word;
                    data_wr_d    = 1'b1;
                    word_cnt_d   = word_cnt_q + 8'd1;
                    first_flag_d = 1'b0;
                    if (head_word[TAIL_BIT] || at_limit) begin
                        state_d     = DONE;
                        pkt_valid_d = 1'b1;
                        if (!head_word[TAIL_BIT]) begin
                            // Truncated packet: mark the forwarded word as tail so
                            // the datapath still sees a closed frame.
                            data_d[TAIL_BIT] = 1'b1;
                            err_trunc_d      = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            qsel_q       <= 2'd0;
            word_cnt_q   <= 8'd0;
            first_flag_q <= 1'b0;
            data_q       <= '0;
            data_wr_q    <= 1'b0;
            pkt_valid_q  <= 1'b0;
            err_trunc_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            qsel_q       <= qsel_d;
            word_cnt_q   <= word_cnt_d;
            first_flag_q <= first_flag_d;
            data_q       <= data_d;
            data_wr_q    <= data_wr_d;
            pkt_valid_q  <= pkt_valid_d;
            err_trunc_q  <= err_trunc_d;
        end
    end

    assign out_ts_q_rden    = rden;
    assign out_ts_q2_rden   = rden[2] && first_flag_q;
    assign out_ts_data      = data_q;
    assign out_ts_data_wr   = data_wr_q;
    assign out_ts_qsel      = qsel_q;
    assign out_ts_pkt_valid = pkt_valid_q;
    assign out_ts_err_trunc = err_trunc_q;

endmodule

// File: tb/tb_ts_queue_sched.sv
// Scoreboard bench for ts_queue_sched: FIFO models feed the DUT, the stimulus
// derives expected output words from queue contents and pushes them, and a
// negedge monitor pops and compares every write and packet-done pulse.
module tb_ts_queue_sched;

    localparam int DW   = 134;
    localparam int MW   = 5;
    localparam int TAIL = DW - 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    valid;
    logic [3:0]    empty;
    logic [DW-1:0] fd [4];
    logic [3:0]    rden;
    logic          q2_rden;
    logic [DW-1:0] data;
    logic          data_wr;
    logic [1:0]    qsel;
    logic          pkt_valid;
    logic          err_trunc;

    logic [DW-1:0] fq [4][$];
    logic [3:0]    stall;

    typedef struct {
        logic [DW-1:0] d;
        bit            last;
        bit            trunc;
        logic [1:0]    q;
    } exp_t;
    exp_t expq[$];

    int checks = 0;
    int errors = 0;
    int cur_q  = 0;
    int reads  = 0;
    int q2_cnt = 0;

    ts_queue_sched #(.DW(DW), .MAX_WORDS(MW)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .in_ts_schedule_valid (valid),
        .in_ts_fifo_empty     (empty),
        .in_ts_q_data_0       (fd[0]),
        .in_ts_q_data_1       (fd[1]),
        .in_ts_q_data_2       (fd[2]),
        .in_ts_q_data_3       (fd[3]),
        .out_ts_q_rden        (rden),
        .out_ts_q2_rden       (q2_rden),
        .out_ts_data          (data),
        .out_ts_data_wr       (data_wr),
        .out_ts_qsel          (qsel),
        .out_ts_pkt_valid     (pkt_valid),
        .out_ts_err_trunc     (err_trunc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-3:0] rand_payload();
        logic [159:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return r[DW-3:0];
    endfunction

    task automatic push_pkt(input int q, input int len, input bit with_tail);
        for (int i = 0; i < len; i++) begin
            fq[q].push_back({(i == 0), (with_tail && i == len - 1), rand_payload()});
        end
    endtask

    // FIFO models: pop what the DUT read at the last edge, then re-present heads.
    initial begin
        logic [3:0] pm;
        for (int i = 0; i < 4; i++) begin
            fd[i]    = '0;
            empty[i] = 1'b1;
        end
        forever begin
            @(negedge clk);
            pm = rst_n ? rden : 4'b0000;
            @(posedge clk);
            #2;
            for (int i = 0; i < 4; i++) begin
                if (pm[i] && fq[i].size() > 0) void'(fq[i].pop_front());
                fd[i]    = (fq[i].size() > 0) ? fq[i][0] : '0;
                empty[i] = (fq[i].size() == 0) || stall[i];
            end
        end
    end

    // Monitor: checks read strobes and pops the scoreboard on every output write.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (rden != 4'b0000) begin
                    chk("rden_onehot", rden, 4'b0001 << cur_q);
                    chk("rden_when_empty", empty[cur_q], 1'b0);
                    chk("q2_rden_first", q2_rden, (cur_q == 2 && reads == 0));
                    reads++;
                end else begin
                    chk("q2_rden_no_read", q2_rden, 1'b0);
                end
                if (q2_rden) q2_cnt++;
                if (data_wr) begin
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got data %0h, expected no write", data);
                    end else begin
                        e = expq.pop_front();
                        chk("data", data, e.d);
                        chk("pkt_valid", pkt_valid, e.last);
                        chk("err_trunc", err_trunc, e.last && e.trunc);
                        chk("qsel", qsel, e.q);
                    end
                end else begin
                    chk("pkt_valid_without_write", pkt_valid, 1'b0);
                    chk("err_trunc_without_write", err_trunc, 1'b0);
                end
                if (pkt_valid) reads = 0;
            end else begin
                reads = 0;
            end
        end
    end

    // One packet: reference selection and word list from the queue model, then
    // run until packet-done with noise on the eligibility vector.
    task automatic run_pkt(input logic [3:0] v, input int exp_edges,
                           input int stall_at, input int stall_len, input bit rnd_stall);
        int   q;
        int   n;
        exp_t e;
        q = 3;
        for (int i = 3; i >= 0; i--) if (v[i]) q = i;
        cur_q = q;
        for (int i = 0; i < fq[q].size(); i++) begin
            e.d     = fq[q][i];
            e.q     = 2'(q);
            e.last  = e.d[TAIL] || (i == MW - 1);
            e.trunc = !e.d[TAIL] && (i == MW - 1);
            if (e.trunc) e.d[TAIL] = 1'b1;
            expq.push_back(e);
            if (e.last) break;
        end
        valid = v;
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            n++;
            if (pkt_valid) break;
            if (n > 300) begin
                checks++;
                errors++;
                $display("FAIL pkt_timeout: got no pkt_valid after %0d cycles, expected one", n);
                break;
            end
            valid    = 4'($urandom);
            stall[q] = (n >= stall_at && n < stall_at + stall_len && stall_len > 0) ||
                       (rnd_stall && $urandom_range(3) == 0);
        end
        valid = 4'b0000;
        stall = 4'b0000;
        if (exp_edges > 0) chk("latency", n, exp_edges);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c0;
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int c0;
        rst_n = 1'b1;
        valid = 4'b0000;
        stall = 4'b0000;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rden", rden, 4'b0000);
        chk("rst_q2_rden", q2_rden, 1'b0);
        chk("rst_data", data, '0);
        chk("rst_data_wr", data_wr, 1'b0);
        chk("rst_qsel", qsel, 2'd0);
        chk("rst_pkt_valid", pkt_valid, 1'b0);
        chk("rst_err_trunc", err_trunc, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Q3 only, 3 words.
        push_pkt(3, 3, 1'b1);
        run_pkt(4'b1000, 4, 0, 0, 1'b0);
        chk("q3_drained", fq[3].size(), 0);
        chk("q3_no_q2_pulse", q2_cnt, 0);

        // Priority: Q0 beats Q2, Q2 left untouched, then Q2 alone.
        push_pkt(0, 2, 1'b1);
        push_pkt(2, 3, 1'b1);
        run_pkt(4'b0101, 3, 0, 0, 1'b0);
        chk("q2_untouched", fq[2].size(), 3);
        run_pkt(4'b0100, 4, 0, 0, 1'b0);
        chk("q2_pulse_count_a", q2_cnt, 1);

        // Q2 token pulse on a 4-word packet.
        c0 = q2_cnt;
        push_pkt(2, 4, 1'b1);
        run_pkt(4'b0100, 5, 0, 0, 1'b0);
        chk("q2_single_pulse", q2_cnt - c0, 1);

        // Q1 stalled for 2 cycles after word 1; tail lands exactly on the word limit.
        push_pkt(1, 5, 1'b1);
        run_pkt(4'b0010, 8, 2, 2, 1'b0);
        chk("stall_drained", fq[1].size(), 0);

        // Truncation at the limit, then the leftover words form the next packet.
        push_pkt(3, 7, 1'b1);
        run_pkt(4'b1000, 6, 0, 0, 1'b0);
        chk("trunc_leftover", fq[3].size(), 2);
        run_pkt(4'b1000, 3, 0, 0, 1'b0);

        // Single-word packet.
        push_pkt(1, 1, 1'b1);
        run_pkt(4'b0010, 2, 0, 0, 1'b0);

        // Reset during word 2 of a Q0 packet.
        push_pkt(0, 5, 1'b1);
        cur_q = 0;
        valid = 4'b0001;
        repeat (2) @(posedge clk);
        #1 valid = 4'b0000;
        chk("pre_reset_data_wr", data_wr, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_rden", rden, 4'b0000);
        chk("mid_rst_data_wr", data_wr, 1'b0);
        chk("mid_rst_data", data, '0);
        chk("mid_rst_pkt_valid", pkt_valid, 1'b0);
        expq.delete();
        fq[0].delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("post_rst_idle_rden", rden, 4'b0000);
            chk("post_rst_idle_wr", data_wr, 1'b0);
        end

        // Randomized packets with random stalls.
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < 4; i++) begin
                if (fq[i].size() == 0) push_pkt(i, $urandom_range(1, 8), 1'b1);
            end
            run_pkt(4'($urandom_range(1, 15)), 0, 0, 0, 1'b1);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
